// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship lane defenders: one-hot state
// encodings, default timing constants and the score ceiling.
package nexys_starship_pkg;

    localparam logic [4:0] DEF_IDLE    = 5'b00001;
    localparam logic [4:0] DEF_ARMED   = 5'b00010;
    localparam logic [4:0] DEF_ENGAGED = 5'b00100;
    localparam logic [4:0] DEF_COOL    = 5'b01000;
    localparam logic [4:0] DEF_OVER    = 5'b10000;

    // 5 s monster lifetime and 250 ms gun cooldown at a 100 MHz system clock
    localparam int DEF_TIMEOUT_CYCLES  = 500_000_000;
    localparam int DEF_COOLDOWN_CYCLES = 25_000_000;
    localparam int DEF_TW              = 32;

    localparam logic [7:0] SCORE_MAX = 8'd255;

    function automatic logic [7:0] satInc(input logic [7:0] value);
        return (value == SCORE_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/starship_timer.sv
// Clearable up-counter with a comparison against a caller-supplied limit.
// One instance per defender is time-shared between the monster timeout and
// the gun cooldown, since those two phases never overlap.
module starship_timer
    import nexys_starship_pkg::*;
#(
    parameter int TW = DEF_TW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [TW-1:0] limit,
    output logic          done,
    output logic [TW-1:0] count
);

    logic [TW-1:0] r_count;

    // Count while enabled; clear has priority so a phase always starts at zero
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign done  = (r_count == limit);
    assign count = r_count;

endmodule

// File: rtl/starship_top_defender.sv
// Player-side responder for the top monster lane: times a present monster,
// accepts the fire pulse, returns a one-cycle kill, keeps the score and
// latches the broken/game-over condition on a timeout.
module starship_top_defender
    import nexys_starship_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int TW              = DEF_TW
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       top_monster,
    input  logic       shoot,
    output logic       top_kill,
    output logic       top_broken,
    output logic       game_over,
    output logic [7:0] score,
    output logic       q_Idle,
    output logic       q_Armed,
    output logic       q_Engaged,
    output logic       q_Cool,
    output logic       q_Over
);

    localparam logic [TW-1:0] LIM_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LIM_COOL    = TW'(COOLDOWN_CYCLES - 1);

    logic [4:0]    r_state;
    logic [4:0]    w_nextState;
    logic          r_kill;
    logic          r_broken;
    logic          r_over;
    logic [7:0]    r_score;
    logic          w_hit;
    logic          w_clear;
    logic          w_enable;
    logic          w_done;
    logic          w_expired;
    logic [TW-1:0] w_limit;
    logic [TW-1:0] w_count;

    // Only COOL uses the cooldown limit; every other state presents the timeout
    assign w_limit  = (r_state == DEF_COOL) ? LIM_COOL : LIM_TIMEOUT;
    assign w_enable = (r_state == DEF_ENGAGED) || (r_state == DEF_COOL);
    assign w_clear  = (w_nextState != r_state);

    // A count beyond the limit can only come from a corrupted register; treating
    // it as expiry keeps the state machine from running away for 2^TW cycles.
    assign w_expired = w_done || (w_count > w_limit);

    starship_timer #(
        .TW(TW)
    ) u_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (w_clear),
        .enable(w_enable),
        .limit (w_limit),
        .done  (w_done),
        .count (w_count)
    );

    // Next-state decode; the order of the checks in each state is the priority
    always_comb begin
        w_nextState = r_state;
        w_hit       = 1'b0;
        case (r_state)
            DEF_IDLE: begin
                if (play_flag) w_nextState = DEF_ARMED;
            end
            DEF_ARMED: begin
                if (!play_flag)       w_nextState = DEF_IDLE;
                else if (top_monster) w_nextState = DEF_ENGAGED;
                else if (shoot)       w_nextState = DEF_COOL;
            end
            DEF_ENGAGED: begin
                if (!play_flag) begin
                    w_nextState = DEF_IDLE;
                end else if (shoot) begin
                    w_hit       = 1'b1;
                    w_nextState = DEF_COOL;
                end else if (w_expired) begin
                    w_nextState = DEF_OVER;
                end else if (!top_monster) begin
                    w_nextState = DEF_ARMED;
                end
            end
            DEF_COOL: begin
                if (!play_flag)     w_nextState = DEF_IDLE;
                else if (w_expired) w_nextState = DEF_ARMED;
            end
            DEF_OVER: begin
                w_nextState = DEF_OVER;
            end
            default: begin
                w_nextState = DEF_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= DEF_IDLE;
        else       r_state <= w_nextState;
    end

    // Registered kill pulse, saturating score and the sticky failure flags
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_kill   <= 1'b0;
            r_broken <= 1'b0;
            r_over   <= 1'b0;
            r_score  <= '0;
        end else begin
            r_kill <= w_hit;
            if ((r_state == DEF_IDLE) && play_flag) begin
                r_score <= '0;
            end else if (w_hit) begin
                r_score <= satInc(r_score);
            end
            if ((r_state == DEF_ENGAGED) && (w_nextState == DEF_OVER)) begin
                r_broken <= 1'b1;
                r_over   <= 1'b1;
            end
        end
    end

    assign top_kill   = r_kill;
    assign top_broken = r_broken;
    assign game_over  = r_over;
    assign score      = r_score;
    assign q_Idle     = r_state[0];
    assign q_Armed    = r_state[1];
    assign q_Engaged  = r_state[2];
    assign q_Cool     = r_state[3];
    assign q_Over     = r_state[4];

endmodule

// File: tb/tb_starship_top_defender.sv
// Self-checking bench for starship_top_defender with short timing constants.
// A behavioural model computes the expected outputs as each stimulus cycle is
// driven and queues them; they are popped and compared one step after the edge.
module tb_starship_top_defender;

    localparam int TO = 10;
    localparam int CD = 4;

    localparam logic [4:0] S_IDLE    = 5'b00001;
    localparam logic [4:0] S_ARMED   = 5'b00010;
    localparam logic [4:0] S_ENGAGED = 5'b00100;
    localparam logic [4:0] S_COOL    = 5'b01000;
    localparam logic [4:0] S_OVER    = 5'b10000;

    typedef struct packed {
        logic       kill;
        logic       broken;
        logic       over;
        logic [7:0] score;
        logic [4:0] st;
    } expect_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       play_flag = 1'b0;
    logic       top_monster = 1'b0;
    logic       shoot = 1'b0;
    logic       top_kill;
    logic       top_broken;
    logic       game_over;
    logic [7:0] score;
    logic       q_Idle;
    logic       q_Armed;
    logic       q_Engaged;
    logic       q_Cool;
    logic       q_Over;

    expect_t    expQ[$];

    logic [4:0] mState;
    int         mCnt;
    logic [7:0] mScore;
    logic       mKill;
    logic       mBroken;
    logic       mOver;

    int compareCount = 0;
    int missCount    = 0;

    starship_top_defender #(
        .TIMEOUT_CYCLES (TO),
        .COOLDOWN_CYCLES(CD),
        .TW             (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .play_flag  (play_flag),
        .top_monster(top_monster),
        .shoot      (shoot),
        .top_kill   (top_kill),
        .top_broken (top_broken),
        .game_over  (game_over),
        .score      (score),
        .q_Idle     (q_Idle),
        .q_Armed    (q_Armed),
        .q_Engaged  (q_Engaged),
        .q_Cool     (q_Cool),
        .q_Over     (q_Over)
    );

    // 100 MHz-style free-running clock
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compareCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mState  = S_IDLE;
        mCnt    = 0;
        mScore  = 8'd0;
        mKill   = 1'b0;
        mBroken = 1'b0;
        mOver   = 1'b0;
    endtask

    task automatic modelStep(input logic pf, input logic tm, input logic sh);
        mKill = 1'b0;
        case (mState)
            S_IDLE: begin
                if (pf) begin
                    mState = S_ARMED;
                    mScore = 8'd0;
                    mCnt   = 0;
                end
            end
            S_ARMED: begin
                if (!pf) mState = S_IDLE;
                else if (tm) begin mState = S_ENGAGED; mCnt = 0; end
                else if (sh) begin mState = S_COOL;    mCnt = 0; end
            end
            S_ENGAGED: begin
                if (!pf) begin
                    mState = S_IDLE;
                end else if (sh) begin
                    mKill = 1'b1;
                    if (mScore != 8'd255) mScore = mScore + 8'd1;
                    mState = S_COOL;
                    mCnt   = 0;
                end else if (mCnt == TO - 1) begin
                    mBroken = 1'b1;
                    mOver   = 1'b1;
                    mState  = S_OVER;
                end else if (!tm) begin
                    mState = S_ARMED;
                end else begin
                    mCnt++;
                end
            end
            S_COOL: begin
                if (!pf) mState = S_IDLE;
                else if (mCnt == CD - 1) mState = S_ARMED;
                else mCnt++;
            end
            default: begin
            end
        endcase
    endtask

    task automatic pushExpected();
        expQ.push_back({mKill, mBroken, mOver, mScore, mState});
    endtask

    task automatic compareDut(input string tag);
        expect_t e;
        if (expQ.size() == 0) begin
            checkOutput({tag, "/queueEmpty"}, 16'd0, 16'd1);
            return;
        end
        e = expQ.pop_front();
        checkOutput({tag, "/kill"},   16'(top_kill),   16'(e.kill));
        checkOutput({tag, "/broken"}, 16'(top_broken), 16'(e.broken));
        checkOutput({tag, "/over"},   16'(game_over),  16'(e.over));
        checkOutput({tag, "/score"},  16'(score),      16'(e.score));
        checkOutput({tag, "/state"},  16'({q_Over, q_Cool, q_Engaged, q_Armed, q_Idle}), 16'(e.st));
    endtask

    task automatic applyStimulus(input string tag, input logic pf, input logic tm, input logic sh);
        play_flag   = pf;
        top_monster = tm;
        shoot       = sh;
        modelStep(pf, tm, sh);
        pushExpected();
        @(posedge Clk);
        #1;
        compareDut(tag);
    endtask

    task automatic midReset(input string tag);
        Reset = 1'b1;
        #2;
        modelReset();
        expQ.delete();
        pushExpected();
        compareDut(tag);
        Reset = 1'b0;
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge Clk);
        #1;
        pushExpected();
        compareDut("reset");
        Reset = 1'b0;

        // Basic kill: shot three cycles after engagement, late monster drop
        applyStimulus("arm", 1, 0, 0);
        applyStimulus("engage", 1, 1, 0);
        repeat (3) applyStimulus("hold", 1, 1, 0);
        applyStimulus("hit", 1, 1, 1);
        applyStimulus("lateDrop", 1, 1, 0);
        repeat (3) applyStimulus("cool", 1, 0, 0);
        applyStimulus("rearmed", 1, 0, 0);

        // Second shot during cooldown is ignored
        applyStimulus("engage2", 1, 1, 0);
        applyStimulus("hold2", 1, 1, 0);
        applyStimulus("shot1", 1, 1, 1);
        applyStimulus("gap", 1, 1, 0);
        applyStimulus("shot2", 1, 1, 1);
        repeat (3) applyStimulus("cool2", 1, 0, 0);

        // Miss in ARMED enters cooldown without scoring
        applyStimulus("miss", 1, 0, 1);
        repeat (4) applyStimulus("coolMiss", 1, 0, 0);

        // Shot on the exact expiry edge wins over the break
        applyStimulus("engage3", 1, 1, 0);
        repeat (TO - 1) applyStimulus("hold3", 1, 1, 0);
        applyStimulus("expiryShot", 1, 1, 1);
        repeat (5) applyStimulus("cool3", 1, 0, 0);

        // Saturate the score and keep hitting
        for (int i = 0; i < 256; i++) begin
            applyStimulus("satEngage", 1, 1, 0);
            applyStimulus("satHit", 1, 1, 1);
            repeat (CD) applyStimulus("satCool", 1, 0, 0);
        end

        // Asynchronous reset while a kill pulse is on the output
        applyStimulus("engage4", 1, 1, 0);
        applyStimulus("hit4", 1, 1, 1);
        midReset("resetKill");

        // Asynchronous reset during ENGAGED with the counter at 5
        applyStimulus("arm5", 1, 0, 0);
        applyStimulus("engage5", 1, 1, 0);
        repeat (5) applyStimulus("hold5", 1, 1, 0);
        midReset("resetEngaged");

        // Timeout breaks the station; flags survive later shoot and play drop
        applyStimulus("arm6", 1, 0, 0);
        applyStimulus("engage6", 1, 1, 0);
        repeat (TO) applyStimulus("hold6", 1, 1, 0);
        applyStimulus("overShoot", 1, 1, 1);
        repeat (3) applyStimulus("overStop", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", compareCount, missCount);
        $finish;
    end

endmodule
